// File: rtl/bus_pkg.sv
// Shared definitions for the bus control-step sequencer and the datapath bus mux.
package bus_pkg;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_LD   = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_JMP  = 3;
    localparam int unsigned OP_HALT = 31;

    typedef enum logic [3:0] {
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_LD_W,
        S_LD_R,
        S_ST_D,
        S_ST_W,
        S_HALT,
        S_FAULT
    } state_t;

    // One-hot bus source selects; the bus mux decodes the same codes.
    localparam int          BUS_W    = 5;
    localparam logic [4:0]  BUS_NONE = 5'b00000;
    localparam logic [4:0]  BUS_PC   = 5'b00001;
    localparam logic [4:0]  BUS_IR   = 5'b00010;
    localparam logic [4:0]  BUS_MAR  = 5'b00100;
    localparam logic [4:0]  BUS_MDR  = 5'b01000;
    localparam logic [4:0]  BUS_R0   = 5'b10000;

    // States in which a memory access is outstanding and mem_ready matters.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_T1) || (s == S_LD_W) || (s == S_ST_W);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready and flags the last permitted one.
// MEM_TIMEOUT = 0 disables the timeout entirely.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic ready,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // Clear while not waiting so every wait state starts from zero; never run past LAST.
    always_ff @(posedge clk) begin
        if (reset || !waiting) begin
            count <= '0;
        end else if (!ready && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    // A ready in the final cycle wins over the timeout.
    assign expired = (MEM_TIMEOUT != 0) && waiting && !ready && (count == LAST);

endmodule

// File: rtl/bus_sequencer.sv
// Control-step sequencer: fetch, decode and execute for NOP/LD/ST/JMP/HALT.
// Sole source of the bus out-enables; outputs are decoded from state, with
// mdr_in qualified by mem_ready in the memory read waits.
//
// state  | meaning
// -------+-----------------------------------------------
// T0     | PC onto bus, load MAR, increment PC
// T1     | fetch read wait, MDR loads from memory on ready
// T2     | MDR onto bus, load IR, count instruction
// T3     | decode ir_opcode
// LD_W   | LD read wait, MDR loads from memory on ready
// LD_R   | MDR onto bus, load R0
// ST_D   | R0 onto bus, load MDR from bus
// ST_W   | ST write wait
// HALT   | stopped by HALT until reset
// FAULT  | illegal opcode or memory timeout until reset
module bus_sequencer
    import bus_pkg::*;
#(
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNTW        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  ir_opcode,
    input  logic            mem_ready,
    output logic            pco,
    output logic            iro,
    output logic            maro,
    output logic            mdro,
    output logic            r0o,
    output logic            pc_in,
    output logic            ir_in,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            r0_in,
    output logic            pc_inc,
    output logic            mdr_sel,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            halted,
    output logic            fault,
    output logic [CNTW-1:0] instr_count
);

    state_t            state;
    logic [CNTW-1:0]   instr_q;
    logic              waiting;
    logic              expired;
    logic [BUS_W-1:0]  bus_sel;

    assign waiting = is_wait_state(state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .waiting (waiting),
        .ready   (mem_ready),
        .expired (expired)
    );

    // State register, next-state decode and fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_T0;
            instr_q <= '0;
        end else begin
            case (state)
                S_T0: state <= S_T1;
                S_T1: begin
                    if (mem_ready)    state <= S_T2;
                    else if (expired) state <= S_FAULT;
                end
                S_T2: begin
                    state   <= S_T3;
                    instr_q <= instr_q + CNTW'(1);
                end
                S_T3: begin
                    if (ir_opcode == OPW'(OP_NOP))       state <= S_T0;
                    else if (ir_opcode == OPW'(OP_LD))   state <= S_LD_W;
                    else if (ir_opcode == OPW'(OP_ST))   state <= S_ST_D;
                    else if (ir_opcode == OPW'(OP_JMP))  state <= S_T0;
                    else if (ir_opcode == OPW'(OP_HALT)) state <= S_HALT;
                    else                                 state <= S_FAULT;
                end
                S_LD_W: begin
                    if (mem_ready)    state <= S_LD_R;
                    else if (expired) state <= S_FAULT;
                end
                S_LD_R: state <= S_T0;
                S_ST_D: state <= S_ST_W;
                S_ST_W: begin
                    if (mem_ready)    state <= S_T0;
                    else if (expired) state <= S_FAULT;
                end
                S_HALT:  state <= S_HALT;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    // Strobe decode; everything is forced low while reset is asserted so a
    // pending memory request is dropped in the reset cycle itself.
    always_comb begin
        bus_sel = BUS_NONE;
        pc_in   = 1'b0;
        ir_in   = 1'b0;
        mar_in  = 1'b0;
        mdr_in  = 1'b0;
        r0_in   = 1'b0;
        pc_inc  = 1'b0;
        mdr_sel = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        if (!reset) begin
            case (state)
                S_T0: begin
                    bus_sel = BUS_PC;
                    mar_in  = 1'b1;
                    pc_inc  = 1'b1;
                end
                S_T1, S_LD_W: begin
                    mem_rd  = 1'b1;
                    mdr_sel = 1'b1;
                    mdr_in  = mem_ready;
                end
                S_T2: begin
                    bus_sel = BUS_MDR;
                    ir_in   = 1'b1;
                end
                S_T3: begin
                    if (ir_opcode == OPW'(OP_LD) || ir_opcode == OPW'(OP_ST)) begin
                        bus_sel = BUS_IR;
                        mar_in  = 1'b1;
                    end else if (ir_opcode == OPW'(OP_JMP)) begin
                        bus_sel = BUS_IR;
                        pc_in   = 1'b1;
                    end
                end
                S_LD_R: begin
                    bus_sel = BUS_MDR;
                    r0_in   = 1'b1;
                end
                S_ST_D: begin
                    bus_sel = BUS_R0;
                    mdr_in  = 1'b1;
                end
                S_ST_W:  mem_wr = 1'b1;
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: fault  = 1'b1;
            endcase
        end
    end

    assign pco  = |(bus_sel & BUS_PC);
    assign iro  = |(bus_sel & BUS_IR);
    assign maro = |(bus_sel & BUS_MAR);
    assign mdro = |(bus_sel & BUS_MDR);
    assign r0o  = |(bus_sel & BUS_R0);

    assign instr_count = reset ? '0 : instr_q;

endmodule
